uart_rx: RTL

//   8N1 UART receiver, the receive end of the SoC's uart_tx line. Recovers bytes from a

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver FSM encodings.
// The transmitter uses the same default bit timing.
package uart_rx_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Reusable two-flop synchronizer for a single asynchronous level signal.
// RESET_VAL selects the value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its source; with = the two stages would collapse into one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a down-counter, byte offered on a
// valid/ready port with a sticky overrun flag and a one-cycle frame-error pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  input  logic                 i_overrun_clr,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 byte_rdy;

  // Line idles high, so the synchronizer must not fake a start bit out of reset.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .d         (i_rx),
    .q         (rx_s)
  );

  assign o_busy = (state != ST_IDLE);

  // NOTE: shreg is reset along with the control state even though it is pure
  // datapath, so an aborted frame can never leak partial bits into a later byte.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_rdy    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      byte_rdy    <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            state <= ST_IDLE;  // start bit vanished by mid-bit: glitch
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            byte_rdy <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            o_frame_err <= 1'b1;
            state       <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register: a pending byte loads only if the slot is free or
  // is being emptied in this same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (byte_rdy && (!o_valid || i_ready)) begin
        o_data  <= shreg;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (byte_rdy && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (i_overrun_clr)               o_overrun <= 1'b0;
    end
  end

endmodule
